// File: rtl/flappy_game_ctrl_pkg.sv
// Shared game definitions: state encodings, default widths and the clock-rate
// constants the clock divider also derives its tick rates from.
package flappy_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LOST  = 2'b11
  } game_state_e;

  localparam int CLK_HZ       = 100_000_000;
  localparam int GAME_TICK_HZ = 50;

  localparam int DEF_SCORE_W         = 10;
  localparam int DEF_NUM_PILLARS     = 2;
  localparam int DEF_DEBOUNCE_CYC    = CLK_HZ / 100;      // 10 ms of stable input
  localparam int DEF_LOST_HOLD_TICKS = 2 * GAME_TICK_HZ;  // 2 s on the game tick

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; level follows din once it has
// held a new value for CYC clks, rise is a one-clk pulse registered with level.
module btn_debounce #(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (CYC < 2) ? 1 : $clog2(CYC);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any clk where the synced input agrees with level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: IDLE/PLAY/PAUSE/LOST FSM, saturating score, high score and
// the post-crash hold-off; flap to flap_pulse is 2 + DEBOUNCE_CYC + 1 clks.
module flappy_game_ctrl
  import flappy_game_ctrl_pkg::*;
#(
  parameter int SCORE_W         = DEF_SCORE_W,
  parameter int NUM_PILLARS     = DEF_NUM_PILLARS,
  parameter int DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
  parameter int LOST_HOLD_TICKS = DEF_LOST_HOLD_TICKS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_game,
  input  logic                   flap_btn,
  input  logic                   pause_sw,
  input  logic                   collision,
  input  logic [NUM_PILLARS-1:0] pillar_pass,
  output logic [1:0]             game_state,
  output logic                   game_run,
  output logic                   game_rst,
  output logic                   flap_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     high_score,
  output logic                   lost,
  output logic                   new_high
);

  localparam int PC_W   = $clog2(NUM_PILLARS + 1);
  localparam int SUM_W  = SCORE_W + 1;
  localparam int HOLD_W = $clog2(LOST_HOLD_TICKS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               new_high_q, new_high_d;
  logic               game_rst_q, game_rst_d;
  logic               flap_pulse_q, flap_pulse_d;
  logic               pause_s1_q, pause_s1_d;
  logic               pause_s2_q, pause_s2_d;

  logic [PC_W-1:0]    pass_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_acc;
  logic               flap_evt;
  logic               flap_level_unused;

  btn_debounce #(
    .CYC (DEBOUNCE_CYC)
  ) u_flap_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (flap_btn),
    .level (flap_level_unused),
    .rise  (flap_evt)
  );

  always_comb begin
    pass_cnt  = PC_W'(popcount8(8'(pillar_pass)));
    score_sum = {1'b0, score_q} + SUM_W'(pass_cnt);
    score_acc = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    hold_d       = hold_q;
    new_high_d   = new_high_q;
    game_rst_d   = 1'b0;
    flap_pulse_d = 1'b0;
    pause_s1_d   = pause_sw;
    pause_s2_d   = pause_s1_q;

    case (state_q)
      ST_IDLE: begin
        if (flap_evt) begin
          state_d    = ST_PLAY;
          game_rst_d = 1'b1;
          score_d    = '0;
          new_high_d = 1'b0;
        end
      end
      ST_PLAY: begin
        // The crash cycle still banks its pillar passes before the high-score compare.
        score_d = score_acc;
        if (collision) begin
          state_d = ST_LOST;
          hold_d  = HOLD_W'(LOST_HOLD_TICKS);
          if (score_acc > high_q) begin
            high_d     = score_acc;
            new_high_d = 1'b1;
          end
        end else if (pause_s2_q) begin
          state_d = ST_PAUSE;
        end else if (flap_evt) begin
          flap_pulse_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!pause_s2_q) begin
          state_d = ST_PLAY;
        end
      end
      ST_LOST: begin
        if (hold_q != '0) begin
          if (tick_game) begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end else if (flap_evt) begin
          state_d    = ST_PLAY;
          game_rst_d = 1'b1;
          score_d    = '0;
          new_high_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      high_q       <= '0;
      hold_q       <= '0;
      new_high_q   <= 1'b0;
      game_rst_q   <= 1'b0;
      flap_pulse_q <= 1'b0;
      pause_s1_q   <= 1'b0;
      pause_s2_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      hold_q       <= hold_d;
      new_high_q   <= new_high_d;
      game_rst_q   <= game_rst_d;
      flap_pulse_q <= flap_pulse_d;
      pause_s1_q   <= pause_s1_d;
      pause_s2_q   <= pause_s2_d;
    end
  end

  assign game_state = state_q;
  assign game_run   = (state_q == ST_PLAY);
  assign lost       = (state_q == ST_LOST);
  assign game_rst   = game_rst_q;
  assign flap_pulse = flap_pulse_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed table, corner-case sequences and random
// stimulus checked every clk against a rule-level reference model.
module tb_flappy_game_ctrl;

  localparam int SW = 4;
  localparam int NP = 2;
  localparam int DC = 4;
  localparam int LH = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, tick_game, flap_btn, pause_sw, collision;
  logic [NP-1:0] pillar_pass;
  logic [1:0]    game_state;
  logic          game_run, game_rst, flap_pulse, lost, new_high;
  logic [SW-1:0] score, high_score;

  always #5 clk = ~clk;

  flappy_game_ctrl #(
    .SCORE_W         (SW),
    .NUM_PILLARS     (NP),
    .DEBOUNCE_CYC    (DC),
    .LOST_HOLD_TICKS (LH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_game   (tick_game),
    .flap_btn    (flap_btn),
    .pause_sw    (pause_sw),
    .collision   (collision),
    .pillar_pass (pillar_pass),
    .game_state  (game_state),
    .game_run    (game_run),
    .game_rst    (game_rst),
    .flap_pulse  (flap_pulse),
    .score       (score),
    .high_score  (high_score),
    .lost        (lost),
    .new_high    (new_high)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: 0 idle, 1 play, 2 pause, 3 lost.
  int m_st, m_score, m_high, m_hold;
  bit m_new_high, m_game_rst, m_flap_pulse, m_level, m_rise;
  bit fh[DC+1];  // fh[k] = flap_btn sampled k+1 edges ago
  bit ph[DC+1];

  task automatic start_game();
    m_st       = 1;
    m_game_rst = 1'b1;
    m_score    = 0;
    m_new_high = 1'b0;
  endtask

  task automatic model_edge();
    bit evt, ps, flip;
    if (!rst_n) begin
      m_st = 0; m_score = 0; m_high = 0; m_hold = 0;
      m_new_high = 0; m_game_rst = 0; m_flap_pulse = 0; m_level = 0; m_rise = 0;
      for (int k = 0; k <= DC; k++) begin
        fh[k] = 1'b0;
        ph[k] = 1'b0;
      end
      return;
    end
    evt = m_rise;
    ps  = ph[1];
    m_game_rst   = 1'b0;
    m_flap_pulse = 1'b0;
    case (m_st)
      0: if (evt) start_game();
      1: begin
        m_score = m_score + $countones(pillar_pass);
        if (m_score > SMAX) m_score = SMAX;
        if (collision) begin
          m_st   = 3;
          m_hold = LH;
          if (m_score > m_high) begin
            m_high     = m_score;
            m_new_high = 1'b1;
          end
        end else if (ps) begin
          m_st = 2;
        end else if (evt) begin
          m_flap_pulse = 1'b1;
        end
      end
      2: if (!ps) m_st = 1;
      default: begin
        if (m_hold != 0) begin
          if (tick_game) m_hold = m_hold - 1;
        end else if (evt) begin
          start_game();
        end
      end
    endcase
    // Debounced level flips once the last DC synced samples all disagree with it.
    flip = 1'b1;
    for (int k = 1; k <= DC; k++) begin
      if (fh[k] == m_level) flip = 1'b0;
    end
    m_rise = flip && !m_level;
    if (flip) m_level = !m_level;
    for (int k = DC; k > 0; k--) begin
      fh[k] = fh[k-1];
      ph[k] = ph[k-1];
    end
    fh[0] = flap_btn;
    ph[0] = pause_sw;
  endtask

  task automatic check_all();
    bit bad;
    n_vec++;
    bad = (int'(game_state) != m_st) || (game_run !== (m_st == 1)) || (lost !== (m_st == 3)) ||
          (int'(score) != m_score) || (int'(high_score) != m_high) || (game_rst !== m_game_rst) ||
          (flap_pulse !== m_flap_pulse) || (new_high !== m_new_high);
    if (bad) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL model cyc=%0d got/exp: state %0d/%0d score %0d/%0d high %0d/%0d rst %0b/%0b flap %0b/%0b new_high %0b/%0b run %0b lost %0b",
                 cyc, game_state, m_st, score, m_score, high_score, m_high, game_rst, m_game_rst,
                 flap_pulse, m_flap_pulse, new_high, m_new_high, game_run, lost);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_all();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press(output int rst_cnt, output int flap_cnt);
    rst_cnt  = 0;
    flap_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      flap_btn = (k < 7);
      step();
      if (game_rst) rst_cnt++;
      if (flap_pulse) flap_cnt++;
    end
  endtask

  task automatic give_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_game = 1'b1;
      step();
      tick_game = 1'b0;
      step();
    end
  endtask

  task automatic add_pp(input logic [NP-1:0] v, input int n);
    pillar_pass = v;
    repeat (n) step();
    pillar_pass = '0;
  endtask

  typedef struct {
    bit       fb;
    bit [1:0] pp;
    int       st;
    int       sc;
    bit       rs;
    bit       fp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit fb, input bit [1:0] pp, input int st, input int sc,
                              input bit rs, input bit fp);
    vec_t v;
    v.fb = fb; v.pp = pp; v.st = st; v.sc = sc; v.rs = rs; v.fp = fp;
    tbl.push_back(v);
  endfunction

  initial begin
    int r, f, pulses, pulse_at, hold_len;
    bit g[8];

    rst_n = 1'b0; flap_btn = 1'b0; pause_sw = 1'b0; collision = 1'b0;
    pillar_pass = '0; tick_game = 1'b0;
    repeat (3) step();
    chk("reset_state", int'(game_state), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_high", int'(high_score), 0);
    chk("reset_outs", int'({game_run, game_rst, flap_pulse, lost, new_high}), 0);
    rst_n = 1'b1;

    // Clean press starts the game 2+4+1 clks later, then saturate, then a flap in PLAY.
    for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 3, 1, 2 * i, 0, 0);
    add(0, 3, 1, 15, 0, 0);
    add(0, 3, 1, 15, 0, 0);
    add(0, 0, 1, 15, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 15, 0, 0);
    add(1, 0, 1, 15, 0, 1);
    add(0, 0, 1, 15, 0, 0);
    foreach (tbl[i]) begin
      flap_btn    = tbl[i].fb;
      pillar_pass = tbl[i].pp;
      step();
      chk($sformatf("tbl%0d_state", i), int'(game_state), tbl[i].st);
      chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
      chk($sformatf("tbl%0d_game_rst", i), int'(game_rst), int'(tbl[i].rs));
      chk($sformatf("tbl%0d_flap_pulse", i), int'(flap_pulse), int'(tbl[i].fp));
    end
    flap_btn = 1'b0;
    pillar_pass = '0;
    repeat (6) step();

    // Bouncy press: 3 high, 1 low, 4 high -> a single flap.
    g = '{1, 1, 1, 0, 1, 1, 1, 1};
    pulses = 0;
    pulse_at = -1;
    for (int k = 0; k < 20; k++) begin
      flap_btn = (k < 8) ? g[k] : 1'b0;
      step();
      if (flap_pulse) begin
        pulses++;
        pulse_at = k;
      end
    end
    chk("glitch_pulse_count", pulses, 1);
    chk("glitch_pulse_time", pulse_at, 10);

    // Fresh session: first game sets high_score to 5.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    press(r, f);
    chk("g1_start_rst", r, 1);
    chk("g1_start_noflap", f, 0);
    add_pp(2'b01, 5);
    collision = 1'b1; step(); collision = 1'b0;
    chk("g1_lost_high", int'(high_score), 5);
    give_ticks(3);
    press(r, f);
    chk("g2_start_state", int'(game_state), 1);
    chk("g2_start_rst", r, 1);
    chk("g2_start_score", int'(score), 0);
    chk("g2_start_new_high", int'(new_high), 0);
    add_pp(2'b01, 5);
    chk("g2_score5", int'(score), 5);
    collision = 1'b1; pillar_pass = 2'b01; step(); collision = 1'b0; pillar_pass = '0;
    chk("crash_state", int'(game_state), 3);
    chk("crash_score", int'(score), 6);
    chk("crash_high", int'(high_score), 6);
    chk("crash_new_high", int'(new_high), 1);
    chk("crash_lost_run", int'({lost, game_run}), 2);

    // Hold-off: two ticks is not enough, the third releases it.
    give_ticks(2);
    press(r, f);
    chk("hold_ignored_state", int'(game_state), 3);
    chk("hold_ignored_rst", r, 0);
    give_ticks(1);
    press(r, f);
    chk("hold_done_state", int'(game_state), 1);
    chk("hold_done_rst", r, 1);
    chk("hold_done_score", int'(score), 0);
    chk("hold_done_high", int'(high_score), 6);

    // Matching the high score is not a new high.
    add_pp(2'b01, 6);
    collision = 1'b1; step(); collision = 1'b0;
    chk("equal_state", int'(game_state), 3);
    chk("equal_new_high", int'(new_high), 0);
    chk("equal_high", int'(high_score), 6);

    // Synced pause and collision on the same clk: collision wins; pause ignored in LOST.
    give_ticks(3);
    press(r, f);
    pause_sw = 1'b1;
    step(); step();
    chk("pause_sync_delay", int'(game_state), 1);
    collision = 1'b1; step(); collision = 1'b0;
    chk("pause_vs_crash", int'(game_state), 3);
    repeat (5) step();
    chk("pause_in_lost", int'(game_state), 3);
    pause_sw = 1'b0;

    // PAUSE ignores collision and pillars; reset mid-pause clears everything.
    give_ticks(3);
    press(r, f);
    pause_sw = 1'b1;
    repeat (3) step();
    chk("paused_state", int'(game_state), 2);
    chk("paused_run", int'(game_run), 0);
    collision = 1'b1; pillar_pass = 2'b11;
    repeat (3) step();
    chk("paused_crash_ignored", int'(game_state), 2);
    chk("paused_score_held", int'(score), 0);
    collision = 1'b0; pillar_pass = '0;
    rst_n = 1'b0; step();
    chk("midpause_rst_state", int'(game_state), 0);
    chk("midpause_rst_high", int'(high_score), 0);
    chk("midpause_rst_score", int'(score), 0);
    chk("midpause_rst_outs", int'({game_run, game_rst, flap_pulse, lost, new_high}), 0);
    rst_n = 1'b1;
    pause_sw = 1'b0;

    // Random traffic against the model.
    hold_len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_len == 0) begin
        flap_btn = 1'($urandom_range(0, 1));
        hold_len = $urandom_range(1, 9);
      end
      hold_len--;
      if ($urandom_range(0, 99) < 3) pause_sw = ~pause_sw;
      collision   = ($urandom_range(0, 99) < 2);
      pillar_pass = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(0, 3)) : 2'b00;
      tick_game   = ($urandom_range(0, 3) == 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
